// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin 4-way arbiter driving a 4:1 mux select; grant timeout enabled by RR_TIMEOUT_EN
module rr_sel_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Req,
    input  logic       Done,
    output logic [1:0] Sel,
    output logic [3:0] Grant,
    output logic       Busy,
    output logic       Timeout
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] sel_q;
    logic [3:0] grant_q;
    logic       busy_q;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       owner_release;
    logic       hold_expired;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_sel_arbiter: HOLD_MAX must be in 1..255");
    end

    // First requester at or after ptr, wrapping mod 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!win_found && Req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_release = Done || !Req[sel_q];

`ifdef RR_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;
    logic       timeout_q;

    assign hold_expired = (hold_cnt == HOLD_LAST);

    // Counter sits at zero in IDLE, so it is already cleared when a grant starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state == ST_IDLE) begin
                hold_cnt <= 8'd0;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
                if (hold_expired && !owner_release)
                    timeout_q <= 1'b1;
            end
        end
    end

    assign Timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign Timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= 2'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        sel_q   <= win_idx;
                        grant_q <= 4'b0001 << win_idx;
                        busy_q  <= 1'b1;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // sel_q is left alone so the mux output stays put while idle.
                    if (owner_release || hold_expired) begin
                        grant_q <= 4'b0000;
                        busy_q  <= 1'b0;
                        ptr     <= sel_q + 2'd1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Sel   = sel_q;
    assign Grant = grant_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - directed vector bench for rr_sel_arbiter
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_sel_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .Req     (req),
        .Done    (done),
        .Sel     (sel),
        .Grant   (grant),
        .Busy    (busy),
        .Timeout (timeout)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t vecs[28];

    task automatic step(input logic r, input logic [3:0] rq, input logic d);
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] e_sel, input logic [3:0] e_grant,
                         input logic e_busy, input logic e_tmo);
        logic [7:0] act;
        logic [7:0] exp_v;
        act   = {sel, grant, busy, timeout};
        exp_v = {e_sel, e_grant, e_busy, e_tmo};
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got sel=%b grant=%b busy=%b timeout=%b, want sel=%b grant=%b busy=%b timeout=%b",
                     name, sel, grant, busy, timeout, e_sel, e_grant, e_busy, e_tmo);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'h0;
        done = 1'b0;

        // reset with all requesting
        vecs[0]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        // rotation 0,1,2,3,0
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'b1111, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        // sparse: ptr=1, req 1001 -> ch3, then ch0
        vecs[12] = '{1'b0, 4'b1001, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 4'b1001, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'b1001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        // other requests ignored during grant
        vecs[15] = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        // withdrawal by ch2, ptr -> 3
        vecs[17] = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
        // Done plus withdrawal together: ptr advances once (3 -> 0)
        vecs[20] = '{1'b0, 4'b0111, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        // Done in IDLE ignored
        vecs[22] = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        // reset mid-grant, ptr back to 0
        vecs[25] = '{1'b1, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vecs[26] = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        vecs[27] = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};

        for (int i = 0; i < 28; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].grant, vecs[i].busy, vecs[i].tmo);
        end

        // ptr is 1; ch0 alone requests and never asserts Done
        step(1'b0, 4'b0001, 1'b0);
        check("hold_grant", 2'd0, 4'b0001, 1'b1, 1'b0);
`ifdef RR_TIMEOUT_EN
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 4'b0001, 1'b0);
            check($sformatf("hold_cyc%0d", i), 2'd0, 4'b0001, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0001, 1'b0);
        check("timeout_pulse", 2'd0, 4'b0000, 1'b0, 1'b1);
        step(1'b0, 4'b0001, 1'b0);
        check("timeout_regrant", 2'd0, 4'b0001, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 4'b0001, 1'b0);
            check($sformatf("hold2_cyc%0d", i), 2'd0, 4'b0001, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0001, 1'b1);
        check("done_at_timeout", 2'd0, 4'b0000, 1'b0, 1'b0);
`else
        for (int i = 1; i <= 100; i++) begin
            step(1'b0, 4'b0001, 1'b0);
            check($sformatf("no_timeout_cyc%0d", i), 2'd0, 4'b0001, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0001, 1'b1);
        check("late_done", 2'd0, 4'b0000, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
